// File: rtl/vpd_access_ctrl.sv
// VPD Address/F-flag handshake controller: a config write to the address dword launches one
// dword read or write against the VPD backing store, and completion is reported by toggling F.
module vpd_access_ctrl #(
  parameter logic [7:0] CAP_ID         = 8'h03,
  parameter logic [7:0] NEXT_PTR       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_wr_en,
  input  logic        cfg_wr_sel,
  input  logic [31:0] cfg_wr_data,
  input  logic [3:0]  cfg_byte_en,
  output logic [31:0] vpd_addr_dword,
  output logic [31:0] vpd_data_dword,
  output logic        mem_req,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        timeout_err,
  output logic        write_dropped
);

  // state   | meaning
  // IDLE    | no access in flight, config writes accepted
  // RD_REQ  | read request presented, waiting for mem_gnt
  // RD_WAIT | read granted, waiting for mem_rvalid
  // WR_REQ  | write request presented, waiting for mem_gnt (posted)
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  localparam int            TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TC_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          f_flag;
  logic [14:0]   addr;
  logic [31:0]   data;
  logic [TW-1:0] tmr;
  logic          launch;
  logic          tc;

  assign launch = cfg_wr_en && !cfg_wr_sel && (cfg_byte_en[3:2] == 2'b11);
  // Down-counter loaded on launch; reaching zero marks the last busy cycle allowed.
  assign tc     = (tmr == '0);

  assign vpd_addr_dword = {f_flag, addr, NEXT_PTR, CAP_ID};
  assign vpd_data_dword = data;
  assign mem_req        = (state == RD_REQ) || (state == WR_REQ);
  assign mem_we         = (state == WR_REQ);
  assign mem_addr       = addr[14:2];
  assign mem_wdata      = data;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      f_flag        <= 1'b0;
      addr          <= '0;
      data          <= '0;
      tmr           <= '0;
      timeout_err   <= 1'b0;
      write_dropped <= 1'b0;
    end else begin
      write_dropped <= cfg_wr_en && (state != IDLE);
      case (state)
        IDLE: begin
          if (cfg_wr_en && cfg_wr_sel) begin
            for (int i = 0; i < 4; i++) begin
              if (cfg_byte_en[i]) data[8*i +: 8] <= cfg_wr_data[8*i +: 8];
            end
          end else if (launch) begin
            addr   <= cfg_wr_data[30:16];
            f_flag <= cfg_wr_data[31];
            tmr    <= TC_LOAD;
            state  <= cfg_wr_data[31] ? WR_REQ : RD_REQ;
          end
        end
        RD_REQ: begin
          if (tc) begin
            data        <= '1;
            f_flag      <= 1'b1;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
            if (mem_gnt) state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A completion on the terminal cycle takes priority over the abort.
          if (mem_rvalid) begin
            data   <= mem_rdata;
            f_flag <= 1'b1;
            state  <= IDLE;
          end else if (tc) begin
            data        <= '1;
            f_flag      <= 1'b1;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        WR_REQ: begin
          if (mem_gnt) begin
            f_flag <= 1'b0;
            state  <= IDLE;
          end else if (tc) begin
            f_flag      <= 1'b0;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpd_access_ctrl.sv
// Self-checking bench for vpd_access_ctrl: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_vpd_access_ctrl;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic        cfg_wr_sel = 1'b0;
  logic [31:0] cfg_wr_data = '0;
  logic [3:0]  cfg_byte_en = '0;
  logic [31:0] vpd_addr_dword, vpd_data_dword, mem_wdata;
  logic        mem_req, mem_we, busy, timeout_err, write_dropped;
  logic [12:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  vpd_access_ctrl #(.CAP_ID(8'h03), .NEXT_PTR(8'h00), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_data(cfg_wr_data),
    .cfg_byte_en(cfg_byte_en),
    .vpd_addr_dword(vpd_addr_dword), .vpd_data_dword(vpd_data_dword),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .timeout_err(timeout_err), .write_dropped(write_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access is pending from launch until its completion or its T-th busy cycle.
  bit          m_f = 0, m_busy = 0, m_wr = 0, m_gnt_seen = 0, m_err = 0, m_drop = 0;
  logic [14:0] m_addr = '0;
  logic [31:0] m_data = '0;
  int          m_age = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_f = 0; m_busy = 0; m_wr = 0; m_gnt_seen = 0; m_err = 0; m_drop = 0;
      m_addr = '0; m_data = '0; m_age = 0;
    end else begin
      m_drop = cfg_wr_en && m_busy;
      if (!m_busy) begin
        if (cfg_wr_en && cfg_wr_sel) begin
          for (int i = 0; i < 4; i++)
            if (cfg_byte_en[i]) m_data[8*i +: 8] = cfg_wr_data[8*i +: 8];
        end else if (cfg_wr_en && cfg_byte_en[3] && cfg_byte_en[2]) begin
          m_addr = cfg_wr_data[30:16];
          m_f = cfg_wr_data[31];
          m_wr = cfg_wr_data[31];
          m_busy = 1; m_gnt_seen = 0; m_age = 0;
        end
      end else begin
        if (m_wr && mem_gnt) begin
          m_f = 0; m_busy = 0;
        end else if (!m_wr && m_gnt_seen && mem_rvalid) begin
          m_data = mem_rdata; m_f = 1; m_busy = 0;
        end else if (m_age == T - 1) begin
          m_err = 1; m_busy = 0;
          if (m_wr) m_f = 0;
          else begin m_f = 1; m_data = 32'hFFFF_FFFF; end
        end else begin
          if (!m_wr && mem_gnt) m_gnt_seen = 1;
          m_age++;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("addr_dword", vpd_addr_dword, {m_f, m_addr, 8'h00, 8'h03});
    check("data_dword", vpd_data_dword, m_data);
    check("busy", 32'(busy), 32'(m_busy));
    check("mem_req", 32'(mem_req), 32'(m_busy && !m_gnt_seen));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
    check("write_dropped", 32'(write_dropped), 32'(m_drop));
    if (m_busy && !m_gnt_seen) begin
      check("mem_we", 32'(mem_we), 32'(m_wr));
      check("mem_addr", 32'(mem_addr), 32'(m_addr[14:2]));
      check("mem_wdata", mem_wdata, m_data);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic sel, input logic [31:0] d, input logic [3:0] be);
    cfg_wr_en = 1'b1; cfg_wr_sel = sel; cfg_wr_data = d; cfg_byte_en = be;
    tick();
    cfg_wr_en = 1'b0; cfg_byte_en = '0;
  endtask

  task automatic pulse_gnt();
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [31:0] d);
    mem_rvalid = 1'b1; mem_rdata = d; tick(); mem_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_addr_dword", vpd_addr_dword, 32'h0000_0003);
    check("rst_data_dword", vpd_data_dword, 32'h0);
    check("rst_busy_req", 32'({busy, mem_req, timeout_err, write_dropped}), 32'h0);
    rst = 1'b0;
    tick();

    // 1: read with gnt two cycles late
    cfg_write(1'b0, 32'h0040_0000, 4'hF);
    check("t1_mem_addr", 32'(mem_addr), 32'h010);
    check("t1_mem_we", 32'(mem_we), 32'h0);
    tick(); tick();
    pulse_gnt();
    check("t1_req_dropped", 32'(mem_req), 32'h0);
    pulse_rvalid(32'hDEAD_BEEF);
    check("t1_data", vpd_data_dword, 32'hDEAD_BEEF);
    check("t1_model_data", m_data, 32'hDEAD_BEEF);
    check("t1_addr_dword", vpd_addr_dword, 32'h8040_0003);
    check("t1_busy", 32'(busy), 32'h0);

    // 2: posted write
    cfg_write(1'b1, 32'h1234_5678, 4'hF);
    cfg_write(1'b0, 32'h8008_0000, 4'hC);
    check("t2_mem_we", 32'(mem_we), 32'h1);
    check("t2_mem_addr", 32'(mem_addr), 32'h002);
    check("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    pulse_gnt();
    check("t2_addr_dword", vpd_addr_dword, 32'h0008_0003);
    check("t2_busy", 32'(busy), 32'h0);

    // 3: partial byte enables
    cfg_write(1'b1, 32'h0, 4'hF);
    cfg_write(1'b1, 32'hAABB_CCDD, 4'b0101);
    check("t3_data", vpd_data_dword, 32'h00BB_00DD);
    cfg_write(1'b0, 32'h8123_0000, 4'b0011);
    check("t3_no_launch", 32'(busy), 32'h0);
    check("t3_addr_kept", vpd_addr_dword, 32'h0008_0003);

    // 4: config writes dropped during RD_WAIT
    cfg_write(1'b0, 32'h0010_0000, 4'hC);
    pulse_gnt();
    cfg_write(1'b1, 32'h5555_5555, 4'hF);
    check("t4_drop_data", 32'(write_dropped), 32'h1);
    cfg_write(1'b0, 32'h8000_0000, 4'hC);
    check("t4_drop_addr", 32'(write_dropped), 32'h1);
    check("t4_data_kept", vpd_data_dword, 32'h00BB_00DD);
    check("t4_addr_kept", vpd_addr_dword, 32'h0010_0003);
    pulse_rvalid(32'hCAFE_F00D);
    check("t4_data", vpd_data_dword, 32'hCAFE_F00D);
    check("t4_addr_dword", vpd_addr_dword, 32'h8010_0003);

    // 5: read never granted -> timeout after T busy cycles
    cfg_write(1'b0, 32'h0000_0000, 4'hC);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("t5_timeout_cycles", 32'(n), 32'(T));
    check("t5_data", vpd_data_dword, 32'hFFFF_FFFF);
    check("t5_f", 32'(vpd_addr_dword[31]), 32'h1);
    check("t5_err", 32'(timeout_err), 32'h1);
    cfg_write(1'b0, 32'h8004_0000, 4'hC);
    pulse_gnt();
    check("t5_err_sticky", 32'(timeout_err), 32'h1);
    check("t5_busy", 32'(busy), 32'h0);

    // 6: reset during RD_WAIT, then stray rvalid
    cfg_write(1'b0, 32'h0020_0000, 4'hC);
    pulse_gnt();
    rst = 1'b1; tick(); rst = 1'b0;
    pulse_rvalid(32'h0BAD_0BAD);
    check("t6_data", vpd_data_dword, 32'h0);
    check("t6_addr_dword", vpd_addr_dword, 32'h0000_0003);
    check("t6_flags", 32'({busy, mem_req, timeout_err}), 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
